fuzzy_sequencer: RTL and testbench
==================================

FUZZY_SEQUENCER -- requirements
Module: fuzzy_sequencer

Interface
REQ-001 Parameter AVG_LOG2, default 2, SHALL set samples averaged per channel to 2^AVG_LOG2.
REQ-002 Parameter SETTLE, default 4, SHALL set cycles waited after ef before risk is sampled (1..15).
REQ-003 Parameters ALARM_ON, default 200, and ALARM_OFF, default 150, SHALL set alarm hysteresis thresholds (ALARM_OFF < ALARM_ON).
REQ-004 Parameter MAX_PCT, default 100, SHALL set the per-sample clamp ceiling.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 in_valid  input  1  sensor sample present.
REQ-008 in_sel  input  1  channel of sample: 0 = rain, 1 = soil.
REQ-009 in_data  input  8  raw sample value.
REQ-010 in_ready  output  1  sample accepted when in_valid and in_ready are both high.
REQ-011 rain  output  8  averaged rainfall driven to the fuzzy estimator.
REQ-012 soil  output  8  averaged soil moisture driven to the fuzzy estimator.
REQ-013 ef  output  1  one-cycle evaluate strobe to the fuzzy estimator.
REQ-014 risk  input  8  risk result returned by the fuzzy estimator.
REQ-015 risk_q  output  8  captured risk value.
REQ-016 risk_valid  output  1  one-cycle pulse, risk_q just updated.
REQ-017 alarm  output  1  hysteretic high-risk flag.
REQ-018 drop  output  1  one-cycle pulse, accepted sample discarded.

Function
REQ-019 FSM states COLLECT, UPDATE, STROBE, SETTLE, CAPTURE SHALL be used; in_ready SHALL be high only in COLLECT.
REQ-020 Each accepted sample SHALL be clamped to MAX_PCT before accumulation.
REQ-021 Per-channel accumulators SHALL be 8+AVG_LOG2 bits wide with saturating-free add; per-channel counters SHALL count to 2^AVG_LOG2.
REQ-022 A sample for a channel whose counter is already full SHALL be discarded, drop SHALL pulse on the following cycle, and accumulators SHALL be unaffected.
REQ-023 COLLECT -> UPDATE on the edge that accepts the sample completing both counters.
REQ-024 UPDATE -> STROBE: rain/soil SHALL load accumulator >> AVG_LOG2 (truncating), accumulators and counters SHALL clear.
REQ-025 ef SHALL be high for exactly the one STROBE cycle, i.e. the cycle after rain/soil change; otherwise low.
REQ-026 SETTLE SHALL last exactly SETTLE cycles, counted by a 4-bit down-counter; then -> CAPTURE.
REQ-027 On entering CAPTURE, risk_q SHALL load risk; risk_valid SHALL be high for the CAPTURE cycle only; CAPTURE -> COLLECT unconditionally.
REQ-028 Alarm update in CAPTURE: risk_q >= ALARM_ON sets alarm, risk_q < ALARM_OFF clears alarm, otherwise alarm holds.
REQ-029 rain/soil SHALL hold stable from UPDATE exit until next UPDATE exit.
REQ-030 Latency: completing-sample acceptance to risk_valid SHALL be SETTLE+3 cycles.

Reset
REQ-031 rst_n low SHALL asynchronously force state COLLECT, all accumulators/counters 0, rain=0, soil=0, ef=0, risk_q=0, risk_valid=0, alarm=0, drop=0, in_ready=1 after release.
REQ-032 Reset asserted mid-SETTLE or mid-STROBE SHALL abort the cycle with no risk_valid pulse.

Structure
REQ-033 State encoding, MAX_PCT, default thresholds SHALL live in a shared package fuzzy_pkg alongside the estimator's constants.
REQ-034 One sub-module, sample_avg (clamp, accumulate, count, divide), SHALL be instantiated twice, one per channel.

Verification
REQ-035 4 rain=40, 4 soil=60 -> rain=40, soil=60, single ef pulse, risk_valid exactly SETTLE+3 cycles after last sample.
REQ-036 rain 10,20,30,41 -> rain=25 (sum 101 truncated).
REQ-037 4 rain=250, soil=0 -> rain=100, soil=0.
REQ-038 Fifth rain sample before soil complete -> drop pulse, rain average unchanged.
REQ-039 risk sequence 210, 180, 140 across three evaluations -> alarm 1, 1, 0.
REQ-040 rst_n low during SETTLE -> all outputs 0 immediately, no risk_valid, next evaluation normal.

Source files
------------

// File: rtl/fuzzy_pkg.sv
// Shared constants for the fuzzy risk sequencer and the fuzzy estimator it drives.
package fuzzy_pkg;

  // Sequencer state encoding
  localparam logic [2:0] ST_COLLECT = 3'd0;
  localparam logic [2:0] ST_UPDATE  = 3'd1;
  localparam logic [2:0] ST_STROBE  = 3'd2;
  localparam logic [2:0] ST_SETTLE  = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;

  // Percentage ceiling applied to raw sensor samples
  localparam int MAX_PCT_DEF = 100;

  // Default alarm hysteresis thresholds on the estimator's risk output
  localparam int ALARM_ON_DEF  = 200;
  localparam int ALARM_OFF_DEF = 150;

  // Estimator operand/result widths
  localparam int PCT_W  = 8;
  localparam int RISK_W = 8;

  typedef logic [PCT_W-1:0] pct_t;

  // Sensor channel selector values
  typedef enum logic {
    CH_RAIN = 1'b0,
    CH_SOIL = 1'b1
  } chan_e;

endpackage

// File: rtl/fuzzy_sequencer_if.sv
// Sensor sample stream: valid/ready handshake carrying a channel tag and a raw value.
interface fuzzy_sequencer_if;
  import fuzzy_pkg::*;

  logic in_valid;
  logic in_sel;
  pct_t in_data;
  logic in_ready;

  modport master (output in_valid, output in_sel, output in_data, input in_ready);
  modport slave  (input in_valid, input in_sel, input in_data, output in_ready);

endinterface

// File: rtl/fuzzy_sequencer_sample_avg.sv
// Per-channel sample averager: clamp, accumulate 2^AVG_LOG2 samples, divide by shift.
module sample_avg
  import fuzzy_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int MAX_PCT  = MAX_PCT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic take,
  input  logic clear,
  input  pct_t data,
  output logic full,
  output logic last,
  output pct_t avg
);

  localparam int ACC_W = PCT_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(1 << AVG_LOG2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_W'(1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  function automatic pct_t clamp_pct(input pct_t v);
    return (v > pct_t'(MAX_PCT)) ? pct_t'(MAX_PCT) : v;
  endfunction

  assign full = (cnt == CNT_MAX);
  assign last = (cnt == CNT_LAST);
  // Truncating divide; the accumulator is wide enough that no sum overflows.
  assign avg  = pct_t'(acc >> AVG_LOG2);

  // Accumulate clamped samples until the block is full; samples arriving when full are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else if (take && !full) begin
      acc <= acc + ACC_W'(clamp_pct(data));
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fuzzy_sequencer.sv
// Collects rain/soil sample blocks, presents their averages to the fuzzy estimator,
// strobes it, waits for it to settle, captures its risk and maintains a hysteretic alarm.
module fuzzy_sequencer
  import fuzzy_pkg::*;
#(
  parameter int AVG_LOG2  = 2,
  parameter int SETTLE    = 4,
  parameter int ALARM_ON  = ALARM_ON_DEF,
  parameter int ALARM_OFF = ALARM_OFF_DEF,
  parameter int MAX_PCT   = MAX_PCT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  fuzzy_sequencer_if.slave    smp,
  output pct_t                rain,
  output pct_t                soil,
  output logic                ef,
  input  pct_t                risk,
  output pct_t                risk_q,
  output logic                risk_valid,
  output logic                alarm,
  output logic                drop
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] settle_cnt;

  logic accept;
  logic rain_take;
  logic soil_take;
  logic rain_full;
  logic soil_full;
  logic rain_last;
  logic soil_last;
  logic chan_full;
  logic complete;
  logic clear;
  logic capture_now;
  pct_t rain_avg;
  pct_t soil_avg;

  assign smp.in_ready = (state == ST_COLLECT);
  assign accept       = smp.in_valid && smp.in_ready;
  assign rain_take    = accept && !smp.in_sel;
  assign soil_take    = accept && smp.in_sel;
  assign chan_full    = smp.in_sel ? soil_full : rain_full;
  // The accepted sample fills its own channel while the other channel is already full.
  assign complete     = accept && !chan_full &&
                        (smp.in_sel ? (soil_last && rain_full) : (rain_last && soil_full));
  assign clear        = (state == ST_UPDATE);
  assign capture_now  = (state == ST_SETTLE) && (settle_cnt == 4'd0);

  sample_avg #(.AVG_LOG2(AVG_LOG2), .MAX_PCT(MAX_PCT)) u_rain (
    .clk   (clk),
    .rst_n (rst_n),
    .take  (rain_take),
    .clear (clear),
    .data  (smp.in_data),
    .full  (rain_full),
    .last  (rain_last),
    .avg   (rain_avg)
  );

  sample_avg #(.AVG_LOG2(AVG_LOG2), .MAX_PCT(MAX_PCT)) u_soil (
    .clk   (clk),
    .rst_n (rst_n),
    .take  (soil_take),
    .clear (clear),
    .data  (smp.in_data),
    .full  (soil_full),
    .last  (soil_last),
    .avg   (soil_avg)
  );

  // Next-state selection for the evaluation cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLLECT: if (complete) state_nxt = ST_UPDATE;
      ST_UPDATE:  state_nxt = ST_STROBE;
      ST_STROBE:  state_nxt = ST_SETTLE;
      ST_SETTLE:  if (settle_cnt == 4'd0) state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = ST_COLLECT;
      default:    state_nxt = ST_COLLECT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_COLLECT;
    else        state <= state_nxt;
  end

  // Settle timer: loaded so that SETTLE spans exactly SETTLE cycles, ending at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         settle_cnt <= 4'd0;
    else if (state == ST_STROBE)        settle_cnt <= 4'(SETTLE - 1);
    else if (state == ST_SETTLE && settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
  end

  // Estimator operands and strobe: averages change on leaving UPDATE, ef marks the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rain <= '0;
      soil <= '0;
      ef   <= 1'b0;
    end else begin
      ef <= (state == ST_UPDATE);
      if (state == ST_UPDATE) begin
        rain <= rain_avg;
        soil <= soil_avg;
      end
    end
  end

  // Risk capture on entry to CAPTURE, with a single-cycle valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      risk_q     <= '0;
      risk_valid <= 1'b0;
    end else begin
      risk_valid <= capture_now;
      if (capture_now) risk_q <= risk;
    end
  end

  // Hysteretic alarm evaluated from the captured risk while in CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm <= 1'b0;
    end else if (state == ST_CAPTURE) begin
      if (risk_q >= pct_t'(ALARM_ON))      alarm <= 1'b1;
      else if (risk_q < pct_t'(ALARM_OFF)) alarm <= 1'b0;
    end
  end

  // Discard indication for a sample accepted on an already-full channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop <= 1'b0;
    else        drop <= accept && chan_full;
  end

endmodule

// File: tb/tb_fuzzy_sequencer.sv
// Testbench for fuzzy_sequencer: table vectors, corner sequences and randomized evaluations.
module tb_fuzzy_sequencer;

  localparam int AVG_LOG2  = 2;
  localparam int SETTLE    = 4;
  localparam int ALARM_ON  = 200;
  localparam int ALARM_OFF = 150;
  localparam int MAX_PCT   = 100;
  localparam int N         = 1 << AVG_LOG2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rain, soil, risk, risk_q;
  logic       ef, risk_valid, alarm, drop;

  fuzzy_sequencer_if smp();

  fuzzy_sequencer #(
    .AVG_LOG2(AVG_LOG2), .SETTLE(SETTLE), .ALARM_ON(ALARM_ON),
    .ALARM_OFF(ALARM_OFF), .MAX_PCT(MAX_PCT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .smp        (smp),
    .rain       (rain),
    .soil       (soil),
    .ef         (ef),
    .risk       (risk),
    .risk_q     (risk_q),
    .risk_valid (risk_valid),
    .alarm      (alarm),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vec = 0;
  int   n_mis = 0;
  int   acc_cyc = 0;
  logic last_drop = 1'b0;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] s;
    logic [7:0]  rk;
    logic [7:0]  er;
    logic [7:0]  es;
    logic        ea;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic sel, input logic [7:0] d);
    int g;
    g = 0;
    @(negedge clk);
    while (!smp.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("ready_timeout", 0, 1);
    smp.in_valid = 1'b1;
    smp.in_sel   = sel;
    smp.in_data  = d;
    acc_cyc      = cyc;
    @(posedge clk);
    #1;
    last_drop    = drop;
    smp.in_valid = 1'b0;
  endtask

  task automatic wait_eval(output int lat, output int efn, output logic [7:0] ef_rain,
                           output logic [7:0] ef_soil, output bit got);
    lat = -1; efn = 0; ef_rain = '0; ef_soil = '0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ef) begin
        efn++;
        ef_rain = rain;
        ef_soil = soil;
      end
      if (risk_valid) begin
        got = 1'b1;
        lat = cyc - acc_cyc;
      end
    end
  endtask

  // Full evaluation with interleaved rain/soil samples, first listed byte sent first.
  task automatic run_eval(input string tag, input logic [31:0] r, input logic [31:0] s,
                          input logic [7:0] rk, input logic [7:0] er, input logic [7:0] es,
                          input logic ea);
    int lat, efn;
    logic [7:0] efr, efs;
    bit got;
    risk = rk;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, r[8*(3-i) +: 8]);
      send(1'b1, s[8*(3-i) +: 8]);
    end
    wait_eval(lat, efn, efr, efs, got);
    chk({tag, "_risk_valid"}, int'(got), 1);
    chk({tag, "_latency"}, lat, SETTLE + 3);
    chk({tag, "_ef_pulses"}, efn, 1);
    chk({tag, "_rain"}, int'(efr), int'(er));
    chk({tag, "_soil"}, int'(efs), int'(es));
    chk({tag, "_risk_q"}, int'(risk_q), int'(rk));
    @(posedge clk);
    #1;
    chk({tag, "_valid_width"}, int'(risk_valid), 0);
    chk({tag, "_alarm"}, int'(alarm), int'(ea));
  endtask

  initial begin
    int cnt [2];
    int sum [2];
    bit m_alarm;
    int lat, efn, guard, rvcount;
    logic [7:0] efr, efs, rk, d;
    logic sel;
    bit got, full;

    smp.in_valid = 1'b0;
    smp.in_sel   = 1'b0;
    smp.in_data  = '0;
    risk         = '0;

    tbl[0] = {{8'd40, 8'd40, 8'd40, 8'd40}, {8'd60, 8'd60, 8'd60, 8'd60}, 8'd210, 8'd40, 8'd60, 1'b1};
    tbl[1] = {{8'd10, 8'd20, 8'd30, 8'd41}, {8'd60, 8'd60, 8'd60, 8'd60}, 8'd180, 8'd25, 8'd60, 1'b1};
    tbl[2] = {{8'd250, 8'd250, 8'd250, 8'd250}, {8'd0, 8'd0, 8'd0, 8'd0}, 8'd140, 8'd100, 8'd0, 1'b0};
    tbl[3] = {{8'd100, 8'd99, 8'd101, 8'd255}, {8'd1, 8'd2, 8'd3, 8'd4}, 8'd150, 8'd99, 8'd2, 1'b0};
    tbl[4] = {{8'd0, 8'd0, 8'd0, 8'd0}, {8'd255, 8'd0, 8'd0, 8'd0}, 8'd200, 8'd0, 8'd25, 1'b1};
    tbl[5] = {{8'd7, 8'd7, 8'd7, 8'd6}, {8'd50, 8'd50, 8'd50, 8'd50}, 8'd149, 8'd6, 8'd50, 1'b0};

    // Reset state
    #12;
    chk("rst_rain", int'(rain), 0);
    chk("rst_soil", int'(soil), 0);
    chk("rst_ef", int'(ef), 0);
    chk("rst_risk_q", int'(risk_q), 0);
    chk("rst_risk_valid", int'(risk_valid), 0);
    chk("rst_alarm", int'(alarm), 0);
    chk("rst_drop", int'(drop), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", int'(smp.in_ready), 1);

    // Table vectors
    for (int i = 0; i < 6; i++)
      run_eval($sformatf("tbl%0d", i), tbl[i].r, tbl[i].s, tbl[i].rk, tbl[i].er, tbl[i].es, tbl[i].ea);

    // Fifth rain sample before soil completes: dropped, average unaffected
    risk = 8'd100;
    for (int i = 0; i < 4; i++) send(1'b0, 8'd40);
    chk("drop_quiet", int'(last_drop), 0);
    send(1'b0, 8'd90);
    chk("drop_pulse", int'(last_drop), 1);
    @(posedge clk);
    #1;
    chk("drop_width", int'(drop), 0);
    for (int i = 0; i < 4; i++) send(1'b1, 8'd60);
    wait_eval(lat, efn, efr, efs, got);
    chk("drop_eval_valid", int'(got), 1);
    chk("drop_rain", int'(efr), 40);
    chk("drop_soil", int'(efs), 60);
    @(posedge clk);
    #1;
    chk("drop_alarm", int'(alarm), 0);

    // Randomized evaluations against the reference model
    m_alarm = 1'b0;
    for (int e = 0; e < 25; e++) begin
      rk   = 8'($urandom_range(0, 255));
      risk = rk;
      cnt[0] = 0; cnt[1] = 0; sum[0] = 0; sum[1] = 0;
      guard = 0;
      while (!(cnt[0] == N && cnt[1] == N) && guard < 200) begin
        sel  = 1'($urandom_range(0, 1));
        d    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(90, 110)) : 8'($urandom_range(0, 255));
        full = (cnt[sel] == N);
        send(sel, d);
        chk("rnd_drop", int'(last_drop), int'(full));
        if (!full) begin
          cnt[sel]++;
          sum[sel] += (d > MAX_PCT) ? MAX_PCT : int'(d);
        end
        guard++;
      end
      wait_eval(lat, efn, efr, efs, got);
      chk("rnd_valid", int'(got), 1);
      chk("rnd_latency", lat, SETTLE + 3);
      chk("rnd_ef", efn, 1);
      chk("rnd_rain", int'(efr), sum[0] / N);
      chk("rnd_soil", int'(efs), sum[1] / N);
      chk("rnd_risk_q", int'(risk_q), int'(rk));
      if (rk >= ALARM_ON) m_alarm = 1'b1;
      else if (rk < ALARM_OFF) m_alarm = 1'b0;
      @(posedge clk);
      #1;
      chk("rnd_alarm", int'(alarm), int'(m_alarm));
    end

    // Reset during SETTLE aborts the evaluation
    run_eval("pre_rst", {8'd80, 8'd80, 8'd80, 8'd80}, {8'd20, 8'd20, 8'd20, 8'd20},
             8'd220, 8'd80, 8'd20, 1'b1);
    risk = 8'd90;
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 8'd30);
      send(1'b1, 8'd30);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rain", int'(rain), 0);
    chk("mid_rst_soil", int'(soil), 0);
    chk("mid_rst_ef", int'(ef), 0);
    chk("mid_rst_risk_q", int'(risk_q), 0);
    chk("mid_rst_risk_valid", int'(risk_valid), 0);
    chk("mid_rst_alarm", int'(alarm), 0);
    chk("mid_rst_drop", int'(drop), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", int'(smp.in_ready), 1);
    rvcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (risk_valid) rvcount++;
    end
    chk("mid_rst_no_valid", rvcount, 0);
    run_eval("post_rst", {8'd40, 8'd40, 8'd40, 8'd40}, {8'd60, 8'd60, 8'd60, 8'd60},
             8'd90, 8'd40, 8'd60, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
